// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused for WIDTH cycles, LSB first,
// with start/done handshake, operand capture and held result registers.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic             Borrow_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic             borrow_reg, borrow_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] r_shift;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The bit shifted out of the result register is never read, so only the
    // upper WIDTH-1 bits are stored; r_shift is the result after this cycle's shift.
    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_shift = cell_d;
        end else begin : g_r_wn
            logic [WIDTH-2:0] r_sh_reg;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n)
                    r_sh_reg <= '0;
                else if (state_reg == RUN)
                    r_sh_reg <= r_shift[WIDTH-1:1];
            end
            assign r_shift = {cell_d, r_sh_reg};
        end
    endgenerate

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        borrow_next = borrow_reg;
        cnt_next    = cnt_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    a_sh_next   = In_A;
                    b_sh_next   = In_B;
                    borrow_next = Borrow_in;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                borrow_next = cell_bout;
                cnt_next    = cnt_reg + CW'(1);
                if (last_bit) begin
                    diff_next  = r_shift;
                    bout_next  = cell_bout;
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start seen in the done cycle launches the next operation directly.
                if (Start) begin
                    a_sh_next   = In_A;
                    b_sh_next   = In_B;
                    borrow_next = Borrow_in;
                    cnt_next    = '0;
                    state_next  = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
        end
    end

    assign Busy       = (state_reg == RUN);
    assign Done       = (state_reg == DONE);
    assign Difference = diff_reg;
    assign Borrow_out = bout_reg;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: an 8-bit instance for the main flows
// and a 1-bit instance for the full-subtractor truth table.

module tb_serial_subtractor_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] in_a, in_b;
    logic       bin;
    logic       busy, done, bout;
    logic [7:0] diff;

    logic       start1, a1, b1, bin1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .In_A(in_a), .In_B(in_b),
        .Borrow_in(bin), .Busy(busy), .Done(done), .Difference(diff), .Borrow_out(bout)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .Start(start1), .In_A(a1), .In_B(b1),
        .Borrow_in(bin1), .Busy(busy1), .Done(done1), .Difference(diff1), .Borrow_out(bout1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "timeout");
    end

    // Presents operands for one edge; called at posedge+1, returns at posedge+1.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
        start = 1'b1; in_a = a; in_b = b; bin = bi;
        @(posedge clk); #1;
        start = 1'b0;
        $display("op start: A=%0d B=%0d Bin=%0d", a, b, bi);
    endtask

    // Counts edges until Done rises (bounded) and cycles spent with Busy high.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0; busy_cycles = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; in_a = 0; in_b = 0; bin = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        #1;
        n_checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            n_fail++; $display("FAIL reset8: got busy=%b done=%b diff=%0d bout=%b, required all 0", busy, done, diff, bout);
        end
        n_checks++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            n_fail++; $display("FAIL reset1: got %b%b%b%b, required 0000", busy1, done1, diff1, bout1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b diff=%0d bout=%b, required all 0", busy, done, diff, bout);
        end
        $display("reset released");
    endtask

    task automatic test_basic;
        int edges, bc;
        start_op(8'd100, 8'd37, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d edges, required 8", edges); end
        n_checks++;
        if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 8", bc); end
        n_checks++;
        if (diff !== 8'd63 || bout !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got diff=%0d bout=%b, required 63/0", diff, bout);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done: got %b, required 0", busy); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || diff !== 8'd63) begin
            n_fail++; $display("FAIL basic_done_pulse: got done=%b diff=%0d, required 0/63", done, diff);
        end
        $display("op done: 100-37-0 -> %0d borrow %b", diff, bout);
    endtask

    task automatic test_borrow;
        int edges, bc;
        start_op(8'd5, 8'd10, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 8 || diff !== 8'd251 || bout !== 1'b1) begin
            n_fail++; $display("FAIL borrow_result: got edges=%0d diff=%0d bout=%b, required 8/251/1", edges, diff, bout);
        end
        $display("op done: 5-10-0 -> %0d borrow %b", diff, bout);
        @(posedge clk); #1;
    endtask

    task automatic test_extremes;
        int edges, bc;
        start_op(8'd0, 8'd0, 1'b1);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 8 || diff !== 8'd255 || bout !== 1'b1) begin
            n_fail++; $display("FAIL zero_minus_bin: got edges=%0d diff=%0d bout=%b, required 8/255/1", edges, diff, bout);
        end
        $display("op done: 0-0-1 -> %0d borrow %b", diff, bout);
        @(posedge clk); #1;
        start_op(8'd255, 8'd255, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 8 || diff !== 8'd0 || bout !== 1'b0) begin
            n_fail++; $display("FAIL ff_minus_ff: got edges=%0d diff=%0d bout=%b, required 8/0/0", edges, diff, bout);
        end
        $display("op done: 255-255-0 -> %0d borrow %b", diff, bout);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int edges, bc, gap;
        start = 1'b1; in_a = 8'd50; in_b = 8'd20; bin = 1'b1;
        @(posedge clk); #1;
        $display("op start: A=50 B=20 Bin=1 (Start held, inputs scrambled)");
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            n_checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                n_fail++; $display("FAIL busy_and_done: got both high, required exclusive");
            end
            in_a = 8'($urandom); in_b = 8'($urandom); bin = 1'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        n_checks++;
        if (edges !== 8 || diff !== 8'd29 || bout !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got edges=%0d diff=%0d bout=%b, required 8/29/0", edges, diff, bout);
        end
        $display("op done: 50-20-1 -> %0d borrow %b", diff, bout);
        in_a = 8'd7; in_b = 8'd9; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        $display("op start: A=7 B=9 Bin=0 (from done cycle)");
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'd29) begin
            n_fail++; $display("FAIL b2b_relaunch: got busy=%b done=%b diff=%0d, required 1/0/29", busy, done, diff);
        end
        wait_done(edges, bc);
        gap = edges + 1;
        n_checks++;
        if (gap !== 9 || diff !== 8'd254 || bout !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got gap=%0d diff=%0d bout=%b, required 9/254/1", gap, diff, bout);
        end
        $display("op done: 7-9-0 -> %0d borrow %b", diff, bout);
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int edges, bc;
        logic saw_done;
        start_op(8'd200, 8'd1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff, bout} !== 11'd0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b done=%b diff=%0d bout=%b, required all 0", busy, done, diff, bout);
        end
        #2 rst_n = 1'b1;
        $display("reset pulsed mid-operation");
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got activity after reset, required idle"); end
        start_op(8'd200, 8'd1, 1'b0);
        wait_done(edges, bc);
        n_checks++;
        if (edges !== 8 || diff !== 8'd199 || bout !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_op: got edges=%0d diff=%0d bout=%b, required 8/199/0", edges, diff, bout);
        end
        $display("op done: 200-1-0 -> %0d borrow %b", diff, bout);
        @(posedge clk); #1;
    endtask

    task automatic test_width1;
        logic [7:0] exp_d = 8'b1001_0110;
        logic [7:0] exp_b = 8'b1000_1110;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            start1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
            @(posedge clk); #1;
            start1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_fail++; $display("FAIL w1_run[%0d]: got busy=%b done=%b, required 1/0", i, busy1, done1);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1[0] !== exp_d[i] || bout1 !== exp_b[i]) begin
                n_fail++; $display("FAIL w1_result[%0d]: got done=%b busy=%b d=%b bo=%b, required 1/0/%b/%b",
                                   i, done1, busy1, diff1[0], bout1, exp_d[i], exp_b[i]);
            end
            $display("op w1: a=%b b=%b bin=%b -> d=%b bo=%b", v[2], v[1], v[0], diff1[0], bout1);
            @(posedge clk); #1;
            n_checks++;
            if (done1 !== 1'b0) begin n_fail++; $display("FAIL w1_pulse[%0d]: got done=%b, required 0", i, done1); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_extremes;
        test_back_to_back;
        test_reset_mid;
        test_width1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences a single instance of the team's Full_Subtractor cell over WIDTH clock cycles, LSB first, to compute In_A - In_B - Borrow_in. It is used where area matters more than latency, and provides a start/done handshake to the surrounding control logic. The block includes operand capture, a borrow flop, result shift register, bit counter and FSM.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
Clk  input  1  system clock, rising-edge.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  request to begin an operation; sampled on the rising edge.
In_A  input  WIDTH  minuend; captured on the accepting edge.
In_B  input  WIDTH  subtrahend; captured on the accepting edge.
Borrow_in  input  1  initial borrow; captured on the accepting edge.
Busy  output  1  high while an operation is in progress (RUN state).
Done  output  1  one-cycle pulse; the result is valid.
Difference  output  WIDTH  registered result, held until the next completion.
Borrow_out  output  1  registered final borrow, held with Difference.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on Rst_n.
- Reset values: state=IDLE, Busy=0, Done=0, Difference=0, Borrow_out=0. Internal operand shift registers, result shift register, borrow flop and counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If Start=1 at an edge, go to RUN.
  - On that edge: A_sh<=In_A, B_sh<=In_B, borrow<=Borrow_in, cnt<=0.
- RUN:
  - The Full_Subtractor inputs are A_sh[0], B_sh[0] and borrow.
  - On each edge: A_sh and B_sh shift right by 1. The difference bit shifts into the MSB of R_sh (R_sh shifts right). borrow<=cell borrow-out. cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that edge processes the final bit and the FSM goes to DONE.
  - On that same edge, Difference<=final R_sh value (including the last bit) and Borrow_out<=final cell borrow-out.
  - Start is ignored in RUN.
  - Inputs In_A, In_B and Borrow_in are don't-care after capture.
- DONE:
  - Done=1 for exactly this cycle.
  - If Start=1 at this edge, the new operands are captured and the FSM goes directly to RUN (back-to-back operation). Otherwise it goes to IDLE.
- Busy is 1 only in RUN. Done is 1 only in DONE. They are never high together.
- Latency: if the accepting edge is E0, the FSM enters DONE at edge E_WIDTH. Done is high during the cycle after E_WIDTH. Throughput is one result per WIDTH+1 cycles; back-to-back starts give one result per WIDTH+1 cycles.
- Arithmetic:
  - Difference = (In_A - In_B - Borrow_in) mod 2^WIDTH.
  - Borrow_out=1 iff In_A < In_B + Borrow_in, treating both as unsigned.
- Difference and Borrow_out change only on entry to DONE. They hold their values through IDLE and the following RUN.
- cnt width is clog2(WIDTH), with a minimum of 1 bit. For WIDTH=1, RUN lasts one cycle.
- Reset mid-operation: asserting Rst_n low in any state immediately returns all outputs to their reset values. No partial result is ever presented. After release, the block waits in IDLE for Start.

Test Plan:
- WIDTH=8, Start with In_A=100, In_B=37, Borrow_in=0 -> Busy high for 8 cycles, then Done pulse for 1 cycle with Difference=63 and Borrow_out=0. Done appears 8 edges after the accepting edge.
- In_A=5, In_B=10, Borrow_in=0 -> Difference=251, Borrow_out=1.
- In_A=0, In_B=0, Borrow_in=1 -> Difference=255, Borrow_out=1. Then In_A=255, In_B=255, Borrow_in=0 -> Difference=0, Borrow_out=0.
- Start held high and In_A/In_B changed every cycle during RUN -> result still matches the operands captured at the accepting edge. Start during RUN is ignored. Start seen in the DONE cycle launches the next operation immediately, with no IDLE cycle between the two Done pulses (9 cycles apart).
- Rst_n pulsed low at the 4th RUN cycle of 200-1 -> Busy, Done, Difference and Borrow_out are all 0 immediately. No Done occurs. A fresh Start of 200-1 then yields 199, Borrow_out=0.
- WIDTH=1 build: all 8 combinations of In_A, In_B and Borrow_in -> Done 1 edge after acceptance. Difference and Borrow_out match the full-subtractor truth table.
